// File: rtl/beam_thresh_pkg.sv
// Shared types and widths for the beamformer threshold loader.
package beam_thresh_pkg;

   // Beam count of beamform_trigger_v2b; also the per-lane chain length.
   localparam int unsigned NBEAMS_DEF = 46;
   localparam int unsigned TBITS      = 18;
   localparam int unsigned NLANES     = 2;

   typedef enum logic {
      LANE_TRIG = 1'b0,
      LANE_SUB  = 1'b1
   } lane_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_AUTO   = 2'd1,
      ST_STREAM = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

endpackage

// File: rtl/beam_thresh_loader_ram.sv
// Shadow threshold RAM: one write port with per-lane enables, one registered read port.
module thresh_shadow_ram
   import beam_thresh_pkg::*;
#(
   parameter int unsigned       DEPTH = NBEAMS_DEF,
   parameter int unsigned       AW    = $clog2(NBEAMS_DEF),
   parameter logic [TBITS-1:0]  INIT  = TBITS'(4000)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NLANES-1:0]        we,
   input  logic [AW-1:0]            waddr,
   input  logic [NLANES*TBITS-1:0]  wdata,
   input  logic                     re,
   input  logic [AW-1:0]            raddr,
   output logic [NLANES*TBITS-1:0]  rdata
);

   // Power-up content only; reset leaves the array untouched.
   logic [NLANES*TBITS-1:0] mem [DEPTH] = '{default: {NLANES{INIT}}};

   // Per-lane write; a same-cycle read of the same entry returns the old value.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NLANES; k++) begin
         if (we[k]) begin
            mem[waddr][k*TBITS +: TBITS] <= wdata[k*TBITS +: TBITS];
         end
      end
   end

   // Registered read; holds its last value when no read is issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/beam_thresh_loader.sv
// Streams shadow thresholds into the trigger's DSP cascade and commits them.
module beam_thresh_loader
   import beam_thresh_pkg::*;
#(
   parameter int unsigned       NBEAMS         = NBEAMS_DEF,
   parameter logic [TBITS-1:0]  DEFAULT_THRESH = TBITS'(4000),
   parameter string             AUTO_LOAD      = "TRUE"
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [$clog2(NBEAMS)-1:0]   wr_addr_i,
   input  logic                        wr_lane_i,
   input  logic [TBITS-1:0]            wr_dat_i,
   input  logic                        wr_en_i,
   input  logic [NLANES-1:0]           apply_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [NLANES*TBITS-1:0]     thresh_o,
   output logic [NLANES-1:0]           thresh_wr_o,
   output logic [NLANES-1:0]           thresh_update_o
);

   localparam int unsigned AW      = $clog2(NBEAMS);
   localparam bit          AUTO_EN = (AUTO_LOAD == "TRUE");

   state_e                   state, state_n;
   logic [NLANES-1:0]        mask, mask_n;
   logic [NLANES-1:0]        pending, pending_n;
   logic [AW-1:0]            rd_idx, rd_idx_n;
   logic                     busy_n, done_n;
   logic [NLANES-1:0]        wr_n, upd_n;
   logic                     rd_en_c;
   logic [NLANES-1:0]        we_c;
   logic [NLANES*TBITS-1:0]  wdata_c;

   // Host write decode; out-of-range beam indices are dropped.
   always_comb begin
      we_c = '0;
      if (wr_en_i && (32'(wr_addr_i) < NBEAMS)) begin
         if (wr_lane_i == LANE_SUB) begin
            we_c[LANE_SUB] = 1'b1;
         end else begin
            we_c[LANE_TRIG] = 1'b1;
         end
      end
   end

   assign wdata_c = {NLANES{wr_dat_i}};

   thresh_shadow_ram #(
      .DEPTH (NBEAMS),
      .AW    (AW),
      .INIT  (DEFAULT_THRESH)
   ) u_ram (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .we    (we_c),
      .waddr (wr_addr_i),
      .wdata (wdata_c),
      .re    (rd_en_c),
      .raddr (rd_idx),
      .rdata (thresh_o)
   );

   // State and registered outputs; reset aborts any load without an update pulse.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state           <= AUTO_EN ? ST_AUTO : ST_IDLE;
         mask            <= '0;
         pending         <= '0;
         rd_idx          <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         thresh_wr_o     <= '0;
         thresh_update_o <= '0;
      end else begin
         state           <= state_n;
         mask            <= mask_n;
         pending         <= pending_n;
         rd_idx          <= rd_idx_n;
         busy_o          <= busy_n;
         done_o          <= done_n;
         thresh_wr_o     <= wr_n;
         thresh_update_o <= upd_n;
      end
   end

   // Next state: read beams high to low, strobe a cycle later, then commit once.
   always_comb begin
      state_n   = state;
      mask_n    = mask;
      pending_n = pending;
      rd_idx_n  = rd_idx;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      wr_n      = '0;
      upd_n     = '0;
      rd_en_c   = 1'b0;
      unique case (state)
         ST_IDLE, ST_AUTO: begin
            if ((state == ST_AUTO) || (apply_i != '0) || (pending != '0)) begin
               mask_n    = (state == ST_AUTO) ? '1 : (apply_i | pending);
               pending_n = '0;
               rd_idx_n  = AW'(NBEAMS - 1);
               busy_n    = 1'b1;
               state_n   = ST_STREAM;
            end
         end
         ST_STREAM: begin
            rd_en_c   = 1'b1;
            wr_n      = mask;
            busy_n    = 1'b1;
            pending_n = pending | apply_i;
            if (rd_idx == '0) begin
               state_n = ST_COMMIT;
            end else begin
               rd_idx_n = rd_idx - AW'(1);
            end
         end
         ST_COMMIT: begin
            upd_n     = mask;
            done_n    = 1'b1;
            busy_n    = 1'b1;
            pending_n = pending | apply_i;
            state_n   = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench: dut_a (4 beams, auto load) and dut_b (5 beams, no auto load).
module tb_beam_thresh_loader;

   localparam int unsigned NA = 4;
   localparam int unsigned NB = 5;

   logic        clk;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        rstn_a, wr_lane_a, wr_en_a;
   logic [1:0]  wr_addr_a, apply_a;
   logic [17:0] wr_dat_a;
   logic        busy_a, done_a;
   logic [35:0] th_a;
   logic [1:0]  twr_a, tupd_a;

   logic        rstn_b, wr_lane_b, wr_en_b;
   logic [2:0]  wr_addr_b;
   logic [1:0]  apply_b;
   logic [17:0] wr_dat_b;
   logic        busy_b, done_b;
   logic [35:0] th_b;
   logic [1:0]  twr_b, tupd_b;

   // Expected per-beam values (index = beam) for the current load.
   logic [17:0] e0 [5];
   logic [17:0] e1 [5];

   beam_thresh_loader #(.NBEAMS(NA), .AUTO_LOAD("TRUE")) dut_a (
      .clk_i(clk), .rstn_i(rstn_a), .wr_addr_i(wr_addr_a), .wr_lane_i(wr_lane_a),
      .wr_dat_i(wr_dat_a), .wr_en_i(wr_en_a), .apply_i(apply_a), .busy_o(busy_a),
      .done_o(done_a), .thresh_o(th_a), .thresh_wr_o(twr_a), .thresh_update_o(tupd_a));

   beam_thresh_loader #(.NBEAMS(NB), .AUTO_LOAD("FALSE")) dut_b (
      .clk_i(clk), .rstn_i(rstn_b), .wr_addr_i(wr_addr_b), .wr_lane_i(wr_lane_b),
      .wr_dat_i(wr_dat_b), .wr_en_i(wr_en_b), .apply_i(apply_b), .busy_o(busy_b),
      .done_o(done_b), .thresh_o(th_b), .thresh_wr_o(twr_b), .thresh_update_o(tupd_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at cycle c of a load whose request was sampled at cycle 0.
   task automatic step_check(input string tag, input int nb, input int c, input logic [1:0] m,
                             input logic busy, input logic done, input logic [1:0] wr,
                             input logic [1:0] upd, input logic [35:0] th);
      logic [1:0] exp_wr;
      exp_wr = (c >= 2 && c <= nb + 1) ? m : 2'b00;
      chk($sformatf("%s c%0d busy", tag, c), 64'(busy), 64'(c >= 1 && c <= nb + 2));
      chk($sformatf("%s c%0d wr", tag, c), 64'(wr), 64'(exp_wr));
      chk($sformatf("%s c%0d upd", tag, c), 64'(upd), 64'((c == nb + 2) ? m : 2'b00));
      chk($sformatf("%s c%0d done", tag, c), 64'(done), 64'(c == nb + 2));
      if (exp_wr[0]) chk($sformatf("%s c%0d lane0", tag, c), 64'(th[17:0]), 64'(e0[nb + 1 - c]));
      if (exp_wr[1]) chk($sformatf("%s c%0d lane1", tag, c), 64'(th[35:18]), 64'(e1[nb + 1 - c]));
   endtask

   task automatic host_wr_a(input logic [1:0] a, input logic l, input logic [17:0] d);
      wr_addr_a = a; wr_lane_a = l; wr_dat_a = d; wr_en_a = 1'b1;
      tick();
      wr_en_a = 1'b0;
   endtask

   task automatic host_wr_b(input logic [2:0] a, input logic l, input logic [17:0] d);
      wr_addr_b = a; wr_lane_b = l; wr_dat_b = d; wr_en_b = 1'b1;
      tick();
      wr_en_b = 1'b0;
   endtask

   task automatic load_a(input string tag, input logic [1:0] m);
      apply_a = m;
      for (int c = 1; c <= NA + 3; c++) begin
         tick();
         apply_a = 2'b00;
         step_check(tag, NA, c, m, busy_a, done_a, twr_a, tupd_a, th_a);
      end
   endtask

   task automatic load_b(input string tag, input logic [1:0] m);
      apply_b = m;
      for (int c = 1; c <= NB + 3; c++) begin
         tick();
         apply_b = 2'b00;
         step_check(tag, NB, c, m, busy_b, done_b, twr_b, tupd_b, th_b);
      end
   endtask

   initial begin
      rstn_a = 1'b0; wr_lane_a = 1'b0; wr_en_a = 1'b0; wr_addr_a = '0; apply_a = '0; wr_dat_a = '0;
      rstn_b = 1'b0; wr_lane_b = 1'b0; wr_en_b = 1'b0; wr_addr_b = '0; apply_b = '0; wr_dat_b = '0;
      repeat (3) tick();

      // Reset state of both instances.
      chk("rst_a busy", 64'(busy_a), 64'd0);
      chk("rst_a done", 64'(done_a), 64'd0);
      chk("rst_a wr", 64'(twr_a), 64'd0);
      chk("rst_a upd", 64'(tupd_a), 64'd0);
      chk("rst_a thresh", 64'(th_a), 64'd0);
      chk("rst_b busy", 64'(busy_b), 64'd0);
      chk("rst_b thresh", 64'(th_b), 64'd0);

      // Auto load of default content on dut_a; dut_b must stay idle.
      e0 = '{4000, 4000, 4000, 4000, 0};
      e1 = '{4000, 4000, 4000, 4000, 0};
      rstn_a = 1'b1;
      rstn_b = 1'b1;
      for (int c = 1; c <= NA + 3; c++) begin
         tick();
         step_check("auto", NA, c, 2'b11, busy_a, done_a, twr_a, tupd_a, th_a);
         chk($sformatf("noauto_b c%0d busy", c), 64'(busy_b), 64'd0);
         chk($sformatf("noauto_b c%0d upd", c), 64'(tupd_b), 64'd0);
      end

      // Lane 0 only load of freshly written values.
      host_wr_a(2'd3, 1'b0, 18'd10);
      host_wr_a(2'd2, 1'b0, 18'd20);
      host_wr_a(2'd1, 1'b0, 18'd30);
      host_wr_a(2'd0, 1'b0, 18'd40);
      e0 = '{40, 30, 20, 10, 0};
      load_a("ld01", 2'b01);

      // Request during a load becomes pending and runs back to back.
      apply_a = 2'b01;
      for (int c = 1; c <= NA + 2; c++) begin
         tick();
         apply_a = (c == 3) ? 2'b10 : 2'b00;
         step_check("b2b1", NA, c, 2'b01, busy_a, done_a, twr_a, tupd_a, th_a);
      end
      apply_a = 2'b00;
      for (int c = 1; c <= NA + 3; c++) begin
         tick();
         step_check("b2b2", NA, c, 2'b10, busy_a, done_a, twr_a, tupd_a, th_a);
      end

      // Writes during a load: beam 0 before its read, beam 3 after its read.
      e0 = '{99, 30, 20, 10, 0};
      apply_a = 2'b01;
      for (int c = 1; c <= NA + 3; c++) begin
         tick();
         apply_a = 2'b00;
         wr_en_a = 1'b0;
         if (c == 2) begin wr_addr_a = 2'd0; wr_lane_a = 1'b0; wr_dat_a = 18'd99; wr_en_a = 1'b1; end
         if (c == 3) begin wr_addr_a = 2'd3; wr_lane_a = 1'b0; wr_dat_a = 18'd77; wr_en_a = 1'b1; end
         step_check("midwr", NA, c, 2'b01, busy_a, done_a, twr_a, tupd_a, th_a);
      end
      wr_en_a = 1'b0;
      e0 = '{99, 30, 20, 77, 0};
      load_a("postwr", 2'b01);

      // dut_b: fill both lanes, then out-of-range writes must be dropped.
      for (int b = 0; b < NB; b++) begin
         host_wr_b(3'(b), 1'b0, 18'(b + 1));
         host_wr_b(3'(b), 1'b1, 18'(101 + b));
      end
      host_wr_b(3'd5, 1'b0, 18'd555);
      host_wr_b(3'd7, 1'b1, 18'd777);
      e0 = '{1, 2, 3, 4, 5};
      e1 = '{101, 102, 103, 104, 105};
      load_b("oor", 2'b11);

      // Reset in the middle of a load with a request pending.
      apply_b = 2'b01;
      for (int c = 1; c <= 3; c++) begin
         tick();
         apply_b = (c == 2) ? 2'b10 : 2'b00;
         if (c == 3) rstn_b = 1'b0;
         step_check("abort", NB, c, 2'b01, busy_b, done_b, twr_b, tupd_b, th_b);
      end
      tick();
      chk("abort busy", 64'(busy_b), 64'd0);
      chk("abort done", 64'(done_b), 64'd0);
      chk("abort wr", 64'(twr_b), 64'd0);
      chk("abort upd", 64'(tupd_b), 64'd0);
      chk("abort thresh", 64'(th_b), 64'd0);
      rstn_b = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("idle_b c%0d busy", c), 64'(busy_b), 64'd0);
         chk($sformatf("idle_b c%0d upd", c), 64'(tupd_b), 64'd0);
         chk($sformatf("idle_b c%0d wr", c), 64'(twr_b), 64'd0);
      end

      // RAM content survives reset.
      load_b("keep", 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
